// File: rtl/mux_arb_nx1.sv
// N:1 registered selector with fixed-select or round-robin arbitration over valid/ready inputs.
// Latency: one cycle from input handshake to out_valid/out_data; one word per cycle sustained.
// Backpressure: a held output word (out_valid & !out_ready) drops every in_ready until it drains.
module mux_arb_nx1 #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = 1 << SELW;

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  rr_gnt;
    logic             rr_found;
    logic [2*N-1:0]   rot;
    logic [SELW:0]    sum;
    logic [SELW-1:0]  gnt;
    logic             gnt_v;
    logic [PW-1:0]    vld_pad;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] gnt_data;
    logic [SELW-1:0]  next_ptr;

    assign can_accept = !out_valid || out_ready;

    // Zero-extended so a select beyond the last channel reads as not-valid.
    assign vld_pad = PW'(in_valid);

    // Rotate the valid vector so bit k corresponds to channel (ptr + k) mod N.
    always_comb begin
        rr_gnt   = '0;
        rr_found = 1'b0;
        sum      = '0;
        rot      = {in_valid, in_valid} >> ptr;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (SELW+1)'(k);
            if (!rr_found && rot[k]) begin
                rr_found = 1'b1;
                rr_gnt   = (sum >= (SELW+1)'(N)) ? SELW'(sum - (SELW+1)'(N)) : SELW'(sum);
            end
        end
    end

    assign gnt   = mode ? rr_gnt : sel;
    assign gnt_v = mode ? (|in_valid) : vld_pad[sel];

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !reset && can_accept && gnt_v && (gnt == SELW'(i));
            if (gnt == SELW'(i))
                gnt_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign xfer     = |(in_valid & in_ready);
    assign next_ptr = (gnt == SELW'(N-1)) ? '0 : gnt + SELW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            out_data  <= gnt_data;
            out_src   <= gnt;
            out_valid <= 1'b1;
            ptr       <= next_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Scoreboarded random/directed bench for mux_arb_nx1 (N=8) plus a directed N=6 instance.
module tb_mux_arb_nx1;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_valid;
    logic           out_ready;

    mux_arb_nx1 #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    logic        s_mode;
    logic [2:0]  s_sel;
    logic [47:0] s_data;
    logic [5:0]  s_valid;
    logic [5:0]  s_rdy;
    logic [7:0]  s_odata;
    logic [2:0]  s_osrc;
    logic        s_ovalid;
    logic        s_oready;

    mux_arb_nx1 #(.WIDTH(8), .N(6)) dut6 (
        .clk(clk), .reset(reset), .mode(s_mode), .sel(s_sel),
        .in_data(s_data), .in_valid(s_valid), .in_ready(s_rdy),
        .out_data(s_odata), .out_src(s_osrc), .out_valid(s_ovalid),
        .out_ready(s_oready)
    );

    typedef struct {
        int           src;
        logic [W-1:0] dat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_ptr = 0;
    bit   m_ov  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin reference: the valid channel at the smallest circular distance from p.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i - p + N) % N) < bd) begin
                bd   = (i - p + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    task automatic drive(input bit m, input int s, input logic [N-1:0] v, input bit r,
                         input logic [N*W-1:0] d, input string name);
        int           g;
        logic [N-1:0] er;
        @(negedge clk);
        mode      = m;
        sel       = SW'(s);
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        #1;
        if (m) g = rr_pick(v, m_ptr);
        else   g = v[s] ? s : -1;
        er = (g >= 0 && (!m_ov || r)) ? (N'(1) << g) : '0;
        chk(name, in_ready, er);
        if (er != '0) begin
            q.push_back('{g, d[g*W +: W]});
            m_ptr = (g + 1) % N;
            m_ov  = 1'b1;
        end else if (r) begin
            m_ov = 1'b0;
        end
    endtask

    // Monitor: any word on the output must be the scoreboard head; it retires when consumed.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!reset && out_valid) begin
                chk("word_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("out_data", out_data, q[0].dat);
                    chk("out_src", out_src, q[0].src);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] d;
        mode = 0; sel = 0; in_valid = '1; in_data = '0; out_ready = 0;
        s_mode = 0; s_sel = 0; s_data = '0; s_valid = '1; s_oready = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst6_in_ready", s_rdy, 0);
        @(negedge clk);
        in_valid = '0;
        s_valid  = '0;
        reset    = 1'b0;

        // N=6: an out-of-range select grants nothing and lets the output drain.
        @(negedge clk);
        for (int i = 0; i < 6; i++) s_data[i*8 +: 8] = 8'($urandom);
        s_sel = 3'd2; s_valid = 6'h3F; s_oready = 1'b1;
        #1 chk("n6_rdy_sel2", s_rdy, 6'b000100);
        @(negedge clk);
        s_sel = 3'd7;
        #1;
        chk("n6_out_valid", s_ovalid, 1);
        chk("n6_out_src", s_osrc, 2);
        chk("n6_out_data", s_odata, s_data[2*8 +: 8]);
        chk("n6_rdy_sel7", s_rdy, 0);
        @(negedge clk);
        s_sel = 3'd3;
        #1;
        chk("n6_drained", s_ovalid, 0);
        chk("n6_rdy_sel3", s_rdy, 6'b001000);
        @(negedge clk);
        s_valid = '0;
        #1;
        chk("n6_out_src3", s_osrc, 3);
        chk("n6_out_data3", s_odata, s_data[3*8 +: 8]);
        chk("n6_out_valid3", s_ovalid, 1);

        // Fixed select of channel 5.
        d = rand_data();
        d[5*W +: W] = 32'hDEADBEEF;
        drive(0, 5, 8'hFF, 1, d, "fixed_sel_rdy");

        // Backpressure for three cycles, then drain and accept together.
        for (int i = 0; i < 3; i++) drive(0, 1, 8'hFF, 0, rand_data(), "bp_rdy");
        drive(0, 2, 8'hFF, 1, rand_data(), "bp_release_rdy");

        // Round-robin skip from ptr=6 with only channels 0 and 2 valid.
        drive(0, 5, 8'hFF, 1, rand_data(), "pre_skip_rdy");
        for (int i = 0; i < 3; i++) drive(1, 0, 8'b0000_0101, 1, rand_data(), "rr_skip_rdy");

        // Reset mid-stream with a word held in the output register.
        drive(0, 3, 8'hFF, 0, rand_data(), "pre_rst_rdy");
        @(negedge clk);
        in_valid  = '1;
        out_ready = 1'b0;
        #5 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_src", out_src, 0);
        chk("midrst_in_ready", in_ready, 0);
        in_valid = '0;
        q.delete();
        m_ov  = 1'b0;
        m_ptr = 0;
        #2 reset = 1'b0;

        // Round-robin fairness and wrap with every channel valid.
        for (int i = 0; i < 10; i++) drive(1, 0, 8'hFF, 1, rand_data(), "rr_all_rdy");

        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 1), $urandom_range(0, N-1), N'($urandom),
                  $urandom_range(0, 3) != 0, rand_data(), "rand_rdy");

        for (int i = 0; i < 4; i++) drive(1, 0, 8'h00, 1, rand_data(), "drain_rdy");
        @(negedge clk);
        #5;
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_arb_nx1.md
# mux_arb_nx1

Parametrised N-input, WIDTH-bit registered selector with valid/ready handshakes on every input and on the output. Successor to the fixed 32-bit 8:1 combinational mux in the datapath. Adds configurable width and channel count, a registered output stage, backpressure, and a round-robin arbitration mode. Intended for sharing one consumer (memory port, ALU operand bus, writeback) among several producers.

## Interface

**Parameters**
- WIDTH, 32, data width per channel
- N, 8, number of input channels (2..16, need not be a power of two)
- SELW, $clog2(N), select/source index width (derived, not overridden)

**Ports**
- clk, input, 1, single clock; all state updates on rising edge
- reset, input, 1, asynchronous, active-high reset
- mode, input, 1, 0 = fixed select by `sel`, 1 = round-robin among valid inputs
- sel, input, SELW, channel index used in mode 0
- in_data, input, N*WIDTH, flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid, input, N, per-channel valid
- in_ready, output, N, per-channel ready (combinational)
- out_data, output, WIDTH, registered selected data
- out_src, output, SELW, registered index of the channel that supplied out_data
- out_valid, output, 1, output register holds a word
- out_ready, input, 1, consumer accepts the word

## Operation

- Single-entry output register (out_data, out_src, out_valid) and a round-robin pointer ptr[SELW-1:0].
- can_accept = !out_valid | out_ready.
- Grant in mode 0: gnt = sel, gnt_v = (sel < N) & in_valid[sel]. If sel >= N, nothing is granted.
- Grant in mode 1: gnt = the first i with in_valid[i] set, scanning ptr, ptr+1, … N-1, 0, … ptr-1 (mod N). gnt_v = |in_valid.
- in_ready[i] = can_accept & gnt_v & (gnt == i). At most one bit is set. in_ready does not depend on in_valid of other channels in mode 0.
- Transfer on channel i when in_valid[i] & in_ready[i]:
  - out_data <= in_data[i]
  - out_src <= i
  - out_valid <= 1
  - ptr <= (i == N-1) ? 0 : i+1
- ptr updates on every transfer in both modes. Mode switches take effect on the next grant evaluation, with no flush.
- Drain with no new transfer (out_valid & out_ready & no grant): out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and accept in the same cycle: the new word replaces the old one, out_valid stays 1. This gives full throughput.
- While out_valid & !out_ready: out_data, out_src and out_valid are held stable, and all in_ready are 0.

## Timing

- Reset (asynchronous assert, synchronous release at the next clk edge):
  - out_valid = 0, out_data = 0, out_src = 0, ptr = 0
  - all in_ready = 0 while reset is high
- Latency: 1 cycle from an input handshake to out_valid/out_data.
- Throughput: 1 word per cycle when out_ready is held high.
- in_ready is combinational from mode, sel, in_valid, out_valid, out_ready and ptr. out_* are registered only, with no combinational input-to-output path.
- Reset asserted mid-transfer: a word in the output register is discarded and out_valid drops immediately (asynchronously). Producers must re-present the word.
- Fairness (mode 1): with all channels continuously valid and out_ready = 1, grants cycle 0,1,…,N-1,0. A given channel waits at most N-1 grants.

## Test plan

1. **Reset:** assert reset mid-stream with out_valid = 1 -> out_valid, out_data and out_src go to 0 the same cycle; after release with mode = 1 and all valid, the first grant is channel 0.
2. **Fixed select:** mode = 0, sel = 5, in_valid = 8'hFF, channel 5 = 32'hDEADBEEF, out_ready = 1 -> in_ready = 8'b0010_0000; next cycle out_data = 32'hDEADBEEF, out_src = 5, out_valid = 1.
3. **Backpressure:** out_valid = 1, out_ready = 0 for 3 cycles -> in_ready = 0 and out_* stable throughout; raise out_ready with a pending input -> drain and new accept in the same cycle, out_valid stays 1.
4. **Round-robin fairness and wrap:** mode = 1, all 8 valid, out_ready = 1 for 10 cycles -> out_src sequence 0,1,2,3,4,5,6,7,0,1.
5. **Round-robin skip:** mode = 1, ptr = 6 (after granting 5), in_valid = 8'b0000_0101 -> next grants 0, then 2, then 0.
6. **Non-power-of-two N:** N = 6, mode = 0, sel = 7, in_valid = 6'h3F -> no in_ready asserted and out_valid falls after drain; then sel = 3 -> channel 3 transferred.
